score_display: RTL

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display_pkg.sv | 24 ++
 rtl/bin2bcd_step.sv | 28 ++
 rtl/score_display.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/score_display_pkg.sv
// Shared constants, state encoding and helpers for the score display block.
//   SCORE_W    : width of the binary score
//   BCD_DIGITS : number of decimal digits shown
//   SCORE_MAX  : largest displayable value; larger scores saturate to it
package score_display_pkg;

  localparam int SCORE_W    = 14;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int SCORE_MAX  = 9999;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Clamp a raw score to the largest value the display can show.
  function automatic logic [SCORE_W-1:0] saturate(input logic [SCORE_W-1:0] v);
    return (v > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : v;
  endfunction

endpackage

// File: rtl/bin2bcd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// {bcd, bin} left by one bit so the binary MSB enters the units digit.
// Ports:
//   bcd_i / bin_i : current BCD accumulator and remaining binary bits
//   bcd_o / bin_o : accumulator and binary after this step
module bin2bcd_step
  import score_display_pkg::*;
(
  input  logic [BCD_W-1:0]   bcd_i,
  input  logic [SCORE_W-1:0] bin_i,
  output logic [BCD_W-1:0]   bcd_o,
  output logic [SCORE_W-1:0] bin_o
);

  logic [BCD_W-1:0] adj;
  logic             unused_msb;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dig
    assign adj[4*g +: 4] = (bcd_i[4*g +: 4] >= 4'd5) ? bcd_i[4*g +: 4] + 4'd3
                                                      : bcd_i[4*g +: 4];
  end

  // The top bit falls off the shift; inputs are clamped to 9999 so it is always 0.
  assign unused_msb = adj[BCD_W-1];
  assign bcd_o      = {adj[BCD_W-2:0], bin_i[SCORE_W-1]};
  assign bin_o      = {bin_i[SCORE_W-2:0], 1'b0};

endmodule

// File: rtl/score_display.sv
// Sequential binary-to-BCD converter for a game score display, with a
// one-deep "latest wins" pending slot and an optional high-score tracker.
// Ports:
//   clk, reset     : clock, async active-high reset
//   score          : binary score, sampled when new_score=1
//   new_score      : strobe, score holds a new value
//   busy           : conversion in progress (SHIFT or DONE)
//   bcd_digits     : last converted score, 4 BCD digits
//   digits_valid   : one-cycle pulse when bcd_digits updates
//   hiscore_bcd    : high score in BCD (0 when the feature is off)
//   hiscore_new    : one-cycle pulse when hiscore_bcd updates
// Build option: define HIGH_SCORE_EN to enable high-score tracking.
module score_display
  import score_display_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score,
  input  logic               new_score,
  output logic               busy,
  output logic [BCD_W-1:0]   bcd_digits,
  output logic               digits_valid,
  output logic [BCD_W-1:0]   hiscore_bcd,
  output logic               hiscore_new
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               dv_q, dv_d;
  logic               pend_q, pend_d;
  logic [SCORE_W-1:0] pend_val_q, pend_val_d;

  logic [BCD_W-1:0]   step_bcd;
  logic [SCORE_W-1:0] step_bin;
  logic               load;
  logic [SCORE_W-1:0] load_val;

  bin2bcd_step u_step (
    .bcd_i (bcd_q),
    .bin_i (bin_q),
    .bcd_o (step_bcd),
    .bin_o (step_bin)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    digits_d   = digits_q;
    dv_d       = 1'b0;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    load       = 1'b0;
    load_val   = saturate(score);
    case (state_q)
      IDLE: begin
        if (new_score) load = 1'b1;
      end
      SHIFT: begin
        bin_d = step_bin;
        bcd_d = step_bcd;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SCORE_W-1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
        if (new_score) begin
          pend_d     = 1'b1;
          pend_val_d = score;
        end
      end
      DONE: begin
        digits_d = bcd_q;
        dv_d     = 1'b1;
        // A strobe in this cycle is newer than anything pending.
        if (new_score) begin
          load = 1'b1;
        end else if (pend_q) begin
          load     = 1'b1;
          load_val = saturate(pend_val_q);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      bin_d   = load_val;
      bcd_d   = '0;
      cnt_d   = '0;
      pend_d  = 1'b0;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      digits_q   <= '0;
      dv_q       <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      digits_q   <= digits_d;
      dv_q       <= dv_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign bcd_digits   = digits_q;
  assign digits_valid = dv_q;

`ifdef HIGH_SCORE_EN
  // cap_q keeps the binary value under conversion for the high-score compare.
  logic [SCORE_W-1:0] cap_q, cap_d;
  logic [SCORE_W-1:0] hi_q, hi_d;
  logic [BCD_W-1:0]   hi_bcd_q, hi_bcd_d;
  logic               hi_new_q, hi_new_d;

  always_comb begin
    cap_d    = load ? load_val : cap_q;
    hi_d     = hi_q;
    hi_bcd_d = hi_bcd_q;
    hi_new_d = 1'b0;
    if (state_q == DONE && cap_q > hi_q) begin
      hi_d     = cap_q;
      hi_bcd_d = bcd_q;
      hi_new_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q    <= '0;
      hi_q     <= '0;
      hi_bcd_q <= '0;
      hi_new_q <= 1'b0;
    end else begin
      cap_q    <= cap_d;
      hi_q     <= hi_d;
      hi_bcd_q <= hi_bcd_d;
      hi_new_q <= hi_new_d;
    end
  end

  assign hiscore_bcd = hi_bcd_q;
  assign hiscore_new = hi_new_q;
`else
  assign hiscore_bcd = '0;
  assign hiscore_new = 1'b0;
`endif

endmodule
